capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter: AUTO_TIMEOUT, 1024, number of sample strobes spent in ARMED before an auto-trigger (used only with CAPTURE_AUTO_TRIG_EN).
REQ-002 Port: clk  in  1  the single system clock; all logic is on its rising edge.
REQ-003 Port: rst_n  in  1  reset; synchronous and active-low.
REQ-004 Port: capture_start  in  1  one-cycle pulse that starts a capture.
REQ-005 Port: stop  in  1  abort; takes priority over every other input.
REQ-006 Port: dump_done  in  1  pulse from the RAM dump path; releases DONE.
REQ-007 Port: trig_in  in  1  asynchronous trigger comparator output.
REQ-008 Port: trig_edge  in  1  1 selects rising edge, 0 selects falling edge.
REQ-009 Port: trig_pos  in  9  number of pre-trigger samples (0..511); latched on start.
REQ-010 Port: decim  in  4  sample period of 2^decim clk cycles; latched on start.
REQ-011 Port: we  out  1  capture-mode select to the RAM interface.
REQ-012 Port: cap_en  out  1  one-cycle RAM write strobe.
REQ-013 Port: cap_addr  out  9  write address.
REQ-014 Port: trace_end  out  9  address of the final sample written.
REQ-015 Port: capture_done, armed, triggered, auto_trig  out  1 each  status flags.

Function
REQ-016 States: IDLE, PRE, ARMED, POST, DONE.
REQ-017 IDLE -> PRE the cycle after capture_start is seen; trig_pos and decim are latched, the decimation counter and pre/post counters are cleared, and cap_addr is kept.
REQ-018 Sample strobe: fires when the decimation counter == 2^decim-1, then the counter wraps to 0; decim=0 gives a strobe every cycle, starting with the first PRE cycle.
REQ-019 we=1 throughout PRE, ARMED and POST, else 0.
REQ-020 On each strobe in PRE, ARMED or POST: cap_en=1 for that cycle with the current cap_addr; cap_addr increments on the next cycle and wraps 511->0.
REQ-021 PRE -> ARMED after the trig_pos-th write; trig_pos=0 sends IDLE directly to ARMED.
REQ-022 Trigger path: 2-flop synchronizer plus one history flop; the edge pulse is valid 3 cycles after trig_in changes.
REQ-023 Trigger edges are ignored outside ARMED.
REQ-024 ARMED -> POST the cycle after the edge pulse; a strobe in the detect cycle is written as a pre-trigger sample.
REQ-025 POST writes exactly 512-trig_pos samples (10-bit counter), then enters DONE; trace_end latches the address of the last write.
REQ-026 DONE: capture_done=1 and we=0; dump_done -> IDLE next cycle; capture_start is ignored in DONE, including when it coincides with dump_done.
REQ-027 stop in any state -> IDLE next cycle; no cap_en in that next cycle; trace_end and cap_addr are unchanged.
REQ-028 armed=1 only in ARMED; triggered=1 in POST and DONE.
REQ-029 capture_start outside IDLE is ignored.

Reset
REQ-030 rst_n low at a clk edge forces IDLE; cap_addr, trace_end, all counters, synchronizer flops and all outputs go to 0.
REQ-031 Reset asserted mid-capture discards the capture; no cap_en occurs in the cycle after reset.

Configuration
REQ-032 With CAPTURE_AUTO_TRIG_EN defined: a strobe counter runs in ARMED, and reaching AUTO_TIMEOUT strobes with no edge forces ARMED -> POST and sets auto_trig=1 until the next IDLE.
REQ-033 Without CAPTURE_AUTO_TRIG_EN: ARMED waits indefinitely, auto_trig is tied to 0, and no timeout counter exists.

Verification
REQ-034 trig_pos=0, decim=0, cap_addr=0, rising edge detected after 100 ARMED writes (addr 0..99) -> 512 POST writes at 100..99 wrapped, trace_end=99, capture_done=1.
REQ-035 trig_pos=256, decim=2 -> cap_en exactly every 4th cycle, 256 writes before armed=1; an edge driven during PRE produces no trigger.
REQ-036 trig_edge=0, trig_in rising pulse only -> stays ARMED; a following falling edge -> triggered=1 four cycles after trig_in falls.
REQ-037 stop asserted in POST after 10 post writes -> IDLE next cycle, no further cap_en, capture_done stays 0.
REQ-038 In DONE, dump_done and capture_start in the same cycle -> IDLE, no new capture; a later capture_start -> PRE.
REQ-039 CAPTURE_AUTO_TRIG_EN defined, AUTO_TIMEOUT=1024, no edge -> POST after 1024 ARMED strobes, auto_trig=1; without the macro -> still ARMED after 5000 strobes.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger RAM capture sequencer; optional auto-trigger when CAPTURE_AUTO_TRIG_EN is defined
module capture_ctrl #(
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture_start,
  input  logic       stop,
  input  logic       dump_done,
  input  logic       trig_in,
  input  logic       trig_edge,
  input  logic [8:0] trig_pos,
  input  logic [3:0] decim,
  output logic       we,
  output logic       cap_en,
  output logic [8:0] cap_addr,
  output logic [8:0] trace_end,
  output logic       capture_done,
  output logic       armed,
  output logic       triggered,
  output logic       auto_trig
);
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
  state_t state, nxt;
  logic [8:0] tp;
  logic [3:0] dc;
  logic [14:0] dcnt;
  logic [8:0] pre_cnt;
  logic [9:0] post_cnt;
  logic s1, s2, h, ep;
  logic active, strobe, wr, pre_last, post_last, edge_hit, timeout;
  assign active = state == PRE || state == ARMED || state == POST;
  assign strobe = active && dcnt == (15'd1 << dc) - 15'd1;
  // stop suppresses the write in its own cycle so cap_addr and trace_end hold
  assign wr = strobe && !stop;
  assign pre_last = wr && state == PRE && pre_cnt == tp - 9'd1;
  assign post_last = wr && state == POST && post_cnt == 10'd511 - {1'b0, tp};
  assign edge_hit = state == ARMED && ep;
`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int AW = $clog2(AUTO_TIMEOUT + 1);
  logic [AW-1:0] acnt;
  logic auto_q;
  assign timeout = state == ARMED && strobe && acnt == AW'(AUTO_TIMEOUT - 1);
  assign auto_trig = auto_q;
  always_ff @(posedge clk) begin
    acnt <= (!rst_n || state != ARMED) ? '0 : strobe ? acnt + 1'b1 : acnt;
    auto_q <= (!rst_n || nxt == IDLE) ? 1'b0 : (timeout && !edge_hit) ? 1'b1 : auto_q;
  end
`else
  assign timeout = 1'b0;
  assign auto_trig = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = capture_start ? (trig_pos == 9'd0 ? ARMED : PRE) : IDLE;
      PRE:     nxt = pre_last ? ARMED : PRE;
      ARMED:   nxt = (edge_hit || timeout) ? POST : ARMED;
      POST:    nxt = post_last ? DONE : POST;
      DONE:    nxt = dump_done ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end
  always_comb begin
    we = active;
    cap_en = wr;
    armed = state == ARMED;
    triggered = state == POST || state == DONE;
    capture_done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp <= '0;
      dc <= '0;
      dcnt <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      cap_addr <= '0;
      trace_end <= '0;
      {s1, s2, h, ep} <= '0;
    end else begin
      if (state == IDLE && capture_start) begin
        tp <= trig_pos;
        dc <= decim;
        dcnt <= '0;
      end else if (active) dcnt <= strobe ? '0 : dcnt + 15'd1;
      pre_cnt <= state != PRE ? '0 : wr ? pre_cnt + 9'd1 : pre_cnt;
      post_cnt <= state != POST ? '0 : wr ? post_cnt + 10'd1 : post_cnt;
      if (wr) cap_addr <= cap_addr + 9'd1;
      if (post_last) trace_end <= cap_addr;
      s1 <= trig_in;
      s2 <= s1;
      h <= s2;
      ep <= trig_edge ? (s2 & ~h) : (~s2 & h);
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: scoreboard bench for capture_ctrl against a cycle-level behavioural model
module tb_capture_ctrl;
  logic clk = 0, rst_n = 0, capture_start = 0, stop = 0, dump_done = 0;
  logic trig_in = 0, trig_edge = 1;
  logic [8:0] trig_pos = 0;
  logic [3:0] decim = 0;
  logic we, cap_en, capture_done, armed, triggered, auto_trig;
  logic [8:0] cap_addr, trace_end;

  capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .capture_start(capture_start), .stop(stop),
    .dump_done(dump_done), .trig_in(trig_in), .trig_edge(trig_edge),
    .trig_pos(trig_pos), .decim(decim), .we(we), .cap_en(cap_en),
    .cap_addr(cap_addr), .trace_end(trace_end), .capture_done(capture_done),
    .armed(armed), .triggered(triggered), .auto_trig(auto_trig)
  );

  always #5 clk = ~clk;

  typedef struct {int c; int a; int ph;} wr_t;
  wr_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  int addr_m = 0, trace_m = 0;
  bit auto_m = 0, mon_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // every write the DUT makes must be the next one the model predicted
  always @(negedge clk) begin
    wr_t e;
    if (mon_on && rst_n && cap_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: cap_addr %0d at cycle %0d, none expected", cap_addr, cyc);
      end else begin
        e = q.pop_front();
        chk("write_cycle", cyc, e.c);
        chk("write_addr", cap_addr, e.a);
        chk("write_phase", {triggered, armed}, e.ph);
        chk("write_we", we, 1);
      end
    end
  end

  // phases: 0 pre, 1 armed, 2 post, 3 done, 4 stopped
  task automatic run(input int tp, input int d, input int edge_t, input int idle,
                     input int c1, input int c2, input int c3,
                     input int stop_k, input int stop_t, input bit with_start);
    int p, ph, nph, pw, qw, a, ts, tend, b, lvl;
    int tg[3];
    int det[3];
    bit st, done;
`ifdef CAPTURE_AUTO_TRIG_EN
    int aw = 0;
`endif
    p = 1 << d; pw = 0; qw = 0; a = addr_m; ts = stop_t; tend = 0;
    tg[0] = c1; tg[1] = c2; tg[2] = c3;
    lvl = idle;
    for (int i = 0; i < 3; i++) begin
      det[i] = -1;
      if (tg[i] >= 0) begin
        lvl = 1 - lvl;
        if (edge_t ? lvl == 1 : lvl == 0) det[i] = tg[i] + 3;
      end
    end
    trig_in = idle[0]; trig_edge = edge_t[0]; trig_pos = tp[8:0]; decim = d[3:0];
    repeat (6) @(posedge clk);
    #1;
    capture_start = 1;
    b = cyc + 1;
    ph = tp == 0 ? 1 : 0;
    for (int t = 0; t < 8000; t++) begin
      st = ((t + 1) % p) == 0;
      tend = t;
      if (t == ts) begin ph = 4; break; end
      nph = ph;
      if (ph < 3 && st) begin q.push_back('{b + t, a, ph}); a = (a + 1) % 512; end
      if (ph == 0 && st) begin pw++; if (pw == tp) nph = 1; end
      if (ph == 1 && (t == det[0] || t == det[1] || t == det[2])) nph = 2;
`ifdef CAPTURE_AUTO_TRIG_EN
      if (ph == 1 && st) begin aw++; if (aw == 1024 && nph == 1) begin nph = 2; auto_m = 1; end end
`endif
      if (ph == 2 && st) begin
        qw++;
        if (qw == 512 - tp) begin nph = 3; trace_m = (a + 511) % 512; end
        else if (qw == stop_k) ts = t + 1;
      end
      ph = nph;
      if (ph == 3) break;
    end
    @(posedge clk);
    #1;
    capture_start = 0;
    for (int t = 0; t <= tend; t++) begin
      for (int i = 0; i < 3; i++) if (t == tg[i]) trig_in = ~trig_in;
      stop = (t == ts);
      @(posedge clk);
      #1;
    end
    stop = 0;
    addr_m = a;
    done = ph == 3;
    chk("capture_done", capture_done, done);
    chk("triggered_end", triggered, done);
    chk("we_end", we, 0);
    chk("armed_end", armed, 0);
    chk("auto_trig_end", auto_trig, auto_m);
    chk("trace_end", trace_end, trace_m);
    chk("cap_addr_end", cap_addr, a);
    chk("queue_drained", q.size(), 0);
    q.delete();
    if (done) begin
      capture_start = 1;
      @(posedge clk);
      #1;
      capture_start = 0;
      chk("done_ignores_start", capture_done, 1);
      chk("done_we", we, 0);
      dump_done = 1;
      capture_start = with_start;
      @(posedge clk);
      #1;
      dump_done = 0;
      capture_start = 0;
      auto_m = 0;
      repeat (3) begin
        chk("idle_after_dump", {capture_done, we, armed, triggered, auto_trig}, 0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int tp, d, e, c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_cap_en", cap_en, 0);
    chk("rst_cap_addr", cap_addr, 0);
    chk("rst_trace_end", trace_end, 0);
    chk("rst_flags", {capture_done, armed, triggered, auto_trig}, 0);
    rst_n = 1;
    mon_on = 1;
    // rising edge after 100 armed writes, dump coinciding with a start
    run(0, 0, 1, 0, 96, -1, -1, 0, -1, 1);
    chk("trace_end_99", trace_end, 99);
    // decimated pre phase; edge during PRE ignored, later edge triggers
    run(256, 2, 1, 0, 10, 200, 1100, 0, -1, 0);
    // falling-edge mode: rising pulse ignored, fall triggers
    run(20, 0, 0, 0, 40, 80, -1, 0, -1, 0);
    // stop after 10 post writes
    run(30, 1, 1, 0, 100, -1, -1, 10, -1, 0);
    // no edge: auto-trigger if built in, otherwise armed until stopped
    run(0, 0, 1, 0, -1, -1, -1, 0, 5000, 0);
    for (int k = 0; k < 4; k++) begin
      tp = $urandom_range(0, 511);
      d = $urandom_range(0, 2);
      e = $urandom_range(0, 1);
      c = tp * (1 << d) + $urandom_range(0, 300);
      run(tp, d, e, 1 - e, c, -1, -1, (k % 2) ? $urandom_range(1, 40) : 0, -1, 0);
    end
    // reset in the middle of a capture
    mon_on = 0;
    trig_pos = 5; decim = 0;
    capture_start = 1;
    @(posedge clk);
    #1;
    capture_start = 0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("midrst_cap_en", cap_en, 0);
    chk("midrst_cap_addr", cap_addr, 0);
    chk("midrst_trace_end", trace_end, 0);
    chk("midrst_flags", {we, capture_done, armed, triggered, auto_trig}, 0);
    @(posedge clk);
    #1;
    chk("midrst_idle", {we, cap_en}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
